// File: rtl/host_page_port.sv
// -----------------------------------------------------------------------------
// host_page_port
//
// Host-side master for the page buffer's host port. One command moves one
// full page (PageWords words) in either direction:
//   - write: host valid/ready stream -> buffer (buf_we/buf_in)
//   - read : buffer (buf_re/buf_out) -> 2-entry skid FIFO -> host valid/ready
// The flash controller owns the buffer's other port; this block never touches
// it. The buffer resets its host-side address whenever buf_sel is low, so
// buf_sel is held high for the whole transfer and dropped for exactly one
// cycle (DONE) at the end, which is what rewinds the buffer address to 0.
//
// Ports:
//   clk, rst            system clock (posedge), async active-high reset
//   wr_start, rd_start  one-cycle command requests (write wins if both)
//   wdata/_valid/_ready host write stream
//   rdata/_valid/_ready host read stream (rdata is the FIFO head, 0 if empty)
//   busy                transfer in progress (state != IDLE)
//   done                one-cycle pulse at the end of a transfer
//   rd_err              sticky: last read ended without host_buf_status seen
//   buf_sel/we/re/in    registered buffer host-port controls and write data
//   buf_out             buffer read data, valid the cycle after buf_re
//   host_buf_status     buffer's read-complete status
// -----------------------------------------------------------------------------
module host_page_port #(
    parameter int DataWidth = 16,
    parameter int PageWords = 2048
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_start,
    input  logic                 rd_start,
    input  logic [DataWidth-1:0] wdata,
    input  logic                 wdata_valid,
    output logic                 wdata_ready,
    output logic [DataWidth-1:0] rdata,
    output logic                 rdata_valid,
    input  logic                 rdata_ready,
    output logic                 busy,
    output logic                 done,
    output logic                 rd_err,
    output logic                 buf_sel,
    output logic                 buf_we,
    output logic                 buf_re,
    output logic [DataWidth-1:0] buf_in,
    input  logic [DataWidth-1:0] buf_out,
    input  logic                 host_buf_status
);

    // Counters must hold PageWords itself, hence the extra bit.
    localparam int              CntW    = $clog2(PageWords) + 1;
    localparam logic [CntW-1:0] PageCnt = CntW'(PageWords);

    typedef enum logic [2:0] {
        IDLE,
        WR_XFER,
        RD_XFER,
        RD_DRAIN,
        DONE
    } state_t;

    state_t               state_q, state_d;
    logic [CntW-1:0]      wcnt_q, wcnt_d;
    logic [CntW-1:0]      icnt_q, icnt_d;
    logic                 buf_sel_q, buf_sel_d;
    logic                 buf_we_q, buf_we_d;
    logic                 buf_re_q, buf_re_d;
    logic [DataWidth-1:0] buf_in_q, buf_in_d;
    logic                 re_d1_q, re_d1_d;
    logic                 status_seen_q, status_seen_d;
    logic                 rd_err_q, rd_err_d;

    // 2-entry skid FIFO on the read path
    logic [DataWidth-1:0] fifo_mem_q [2];
    logic [DataWidth-1:0] fifo_mem_d [2];
    logic                 fifo_wp_q, fifo_wp_d;
    logic                 fifo_rp_q, fifo_rp_d;
    logic [1:0]           fifo_count_q, fifo_count_d;

    logic                 wr_accept;
    logic                 fifo_push;
    logic                 fifo_pop;
    logic                 rd_issue;
    logic [2:0]           rd_pending;

    // ------------------------------------------------------------------
    // Output decode (all from registers)
    // ------------------------------------------------------------------
    assign wdata_ready = (state_q == WR_XFER) && (wcnt_q < PageCnt);
    assign rdata_valid = (fifo_count_q != 2'd0);
    assign rdata       = rdata_valid ? fifo_mem_q[fifo_rp_q] : '0;
    assign busy        = (state_q != IDLE);
    assign done        = (state_q == DONE);
    assign rd_err      = rd_err_q;
    assign buf_sel     = buf_sel_q;
    assign buf_we      = buf_we_q;
    assign buf_re      = buf_re_q;
    assign buf_in      = buf_in_q;

    // ------------------------------------------------------------------
    // Next-state / datapath
    // ------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        wcnt_d        = wcnt_q;
        icnt_d        = icnt_q;
        buf_we_d      = 1'b0;
        buf_re_d      = 1'b0;
        buf_in_d      = buf_in_q;
        re_d1_d       = buf_re_q;
        status_seen_d = status_seen_q;
        rd_err_d      = rd_err_q;
        fifo_mem_d    = fifo_mem_q;
        fifo_wp_d     = fifo_wp_q;
        fifo_rp_d     = fifo_rp_q;

        wr_accept = wdata_valid && wdata_ready;

        // buf_out carries the word requested by the previous cycle's buf_re.
        fifo_push = re_d1_q;
        fifo_pop  = rdata_valid && rdata_ready;

        // Words that will occupy the FIFO: current contents net of this
        // cycle's pop, plus the word on buf_out now and the one requested
        // this cycle. A new request is only allowed if it still fits in 2.
        rd_pending = {1'b0, fifo_count_q} - {2'b00, fifo_pop}
                   + {2'b00, buf_re_q} + {2'b00, re_d1_q};
        rd_issue   = (state_q == RD_XFER) && (icnt_q < PageCnt)
                   && (rd_pending < 3'd2);

        if (fifo_push) begin
            fifo_mem_d[fifo_wp_q] = buf_out;
            fifo_wp_d             = ~fifo_wp_q;
        end
        if (fifo_pop) begin
            fifo_rp_d = ~fifo_rp_q;
        end
        fifo_count_d = fifo_count_q + {1'b0, fifo_push} - {1'b0, fifo_pop};

        unique case (state_q)
            IDLE: begin
                if (wr_start) begin
                    state_d       = WR_XFER;
                    wcnt_d        = '0;
                    icnt_d        = '0;
                    status_seen_d = 1'b0;
                    rd_err_d      = 1'b0;
                end else if (rd_start) begin
                    state_d       = RD_XFER;
                    wcnt_d        = '0;
                    icnt_d        = '0;
                    status_seen_d = 1'b0;
                    rd_err_d      = 1'b0;
                end
            end

            WR_XFER: begin
                if (wr_accept) begin
                    buf_we_d = 1'b1;
                    buf_in_d = wdata;
                    wcnt_d   = wcnt_q + 1'b1;
                end
                // wcnt reaches PageWords in the cycle that carries the
                // final buf_we, so the next cycle is DONE.
                if (wcnt_q == PageCnt) begin
                    state_d = DONE;
                end
            end

            RD_XFER: begin
                buf_re_d = rd_issue;
                if (rd_issue) begin
                    icnt_d = icnt_q + 1'b1;
                end
                if (host_buf_status) begin
                    status_seen_d = 1'b1;
                end
                if (icnt_q == PageCnt) begin
                    state_d = RD_DRAIN;
                end
            end

            RD_DRAIN: begin
                if (host_buf_status) begin
                    status_seen_d = 1'b1;
                end
                // Leave as soon as the last word is handed to the host.
                if (!re_d1_q && ((fifo_count_q == 2'd0) ||
                                 ((fifo_count_q == 2'd1) && fifo_pop))) begin
                    state_d = DONE;
                    if (!(status_seen_q || host_buf_status)) begin
                        rd_err_d = 1'b1;
                    end
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // Registered so buf_sel is high exactly while the state is a
        // transfer state and low in DONE/IDLE.
        buf_sel_d = (state_d == WR_XFER) || (state_d == RD_XFER)
                 || (state_d == RD_DRAIN);
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            wcnt_q        <= '0;
            icnt_q        <= '0;
            buf_sel_q     <= 1'b0;
            buf_we_q      <= 1'b0;
            buf_re_q      <= 1'b0;
            buf_in_q      <= '0;
            re_d1_q       <= 1'b0;
            status_seen_q <= 1'b0;
            rd_err_q      <= 1'b0;
            fifo_mem_q[0] <= '0;
            fifo_mem_q[1] <= '0;
            fifo_wp_q     <= 1'b0;
            fifo_rp_q     <= 1'b0;
            fifo_count_q  <= 2'd0;
        end else begin
            state_q       <= state_d;
            wcnt_q        <= wcnt_d;
            icnt_q        <= icnt_d;
            buf_sel_q     <= buf_sel_d;
            buf_we_q      <= buf_we_d;
            buf_re_q      <= buf_re_d;
            buf_in_q      <= buf_in_d;
            re_d1_q       <= re_d1_d;
            status_seen_q <= status_seen_d;
            rd_err_q      <= rd_err_d;
            fifo_mem_q[0] <= fifo_mem_d[0];
            fifo_mem_q[1] <= fifo_mem_d[1];
            fifo_wp_q     <= fifo_wp_d;
            fifo_rp_q     <= fifo_rp_d;
            fifo_count_q  <= fifo_count_d;
        end
    end

endmodule

// File: tb/tb_host_page_port.sv
// -----------------------------------------------------------------------------
// tb_host_page_port
//
// Bench for host_page_port. A simple page-buffer model sits on the buffer
// host port (address rewinds whenever buf_sel is low, read data one cycle
// after buf_re, read-complete status once the last word of a filled page is
// read). Expected results come from the page contents: a write must leave the
// host words at buffer addresses 0..PageWords-1, a read must return the
// preloaded page in order.
// -----------------------------------------------------------------------------
module tb_host_page_port;

    localparam int DW = 16;
    localparam int PW = 2048;
    localparam int XFER_BUDGET = 10000;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_start = 1'b0;
    logic          rd_start = 1'b0;
    logic [DW-1:0] wdata = '0;
    logic          wdata_valid = 1'b0;
    logic          wdata_ready;
    logic [DW-1:0] rdata;
    logic          rdata_valid;
    logic          rdata_ready = 1'b0;
    logic          busy, done, rd_err;
    logic          buf_sel, buf_we, buf_re;
    logic [DW-1:0] buf_in;
    logic [DW-1:0] buf_out_m = '0;
    logic          status_m = 1'b0;

    always #5 clk = ~clk;

    host_page_port #(.DataWidth(DW), .PageWords(PW)) dut (
        .clk(clk), .rst(rst),
        .wr_start(wr_start), .rd_start(rd_start),
        .wdata(wdata), .wdata_valid(wdata_valid), .wdata_ready(wdata_ready),
        .rdata(rdata), .rdata_valid(rdata_valid), .rdata_ready(rdata_ready),
        .busy(busy), .done(done), .rd_err(rd_err),
        .buf_sel(buf_sel), .buf_we(buf_we), .buf_re(buf_re),
        .buf_in(buf_in), .buf_out(buf_out_m), .host_buf_status(status_m)
    );

    // ---------------- page buffer model ----------------
    logic [DW-1:0] bmem      [PW];
    logic [DW-1:0] fill_data [PW];
    logic [DW-1:0] wr_words  [PW];
    logic          fill_req    = 1'b0;
    logic          page_filled = 1'b0;
    int            haddr = 0;

    always @(posedge clk) begin
        if (fill_req) begin
            for (int i = 0; i < PW; i++) bmem[i] <= fill_data[i];
        end
        if (!buf_sel) begin
            haddr    <= 0;
            status_m <= 1'b0;
        end else begin
            if (buf_we) begin
                if (haddr < PW) bmem[haddr] <= buf_in;
                haddr <= haddr + 1;
            end
            if (buf_re) begin
                buf_out_m <= (haddr < PW) ? bmem[haddr] : '0;
                haddr     <= haddr + 1;
                if (haddr == PW - 1 && page_filled) status_m <= 1'b1;
            end
        end
    end

    // ---------------- bus monitor ----------------
    int cyc = 0, we_tot = 0, re_tot = 0, pop_tot = 0, done_tot = 0;
    int sel_drop = 0, flow_err = 0, ctl_err = 0;
    int last_pop_cyc = 0, done_cyc = 0;
    logic [DW-1:0] rd_log [$];

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (buf_we) we_tot <= we_tot + 1;
        if (buf_re) re_tot <= re_tot + 1;
        // requested-but-not-consumed words may never exceed the FIFO depth
        if ((re_tot + int'(buf_re)) - pop_tot > 2) flow_err <= flow_err + 1;
        if (rdata_valid && rdata_ready) begin
            rd_log.push_back(rdata);
            pop_tot      <= pop_tot + 1;
            last_pop_cyc <= cyc;
        end
        if (done) begin
            done_tot <= done_tot + 1;
            done_cyc <= cyc;
        end
        if (busy && !done && !buf_sel) sel_drop <= sel_drop + 1;
        if ((buf_we || buf_re) && !buf_sel) ctl_err <= ctl_err + 1;
        if (done && (buf_sel || buf_we || buf_re)) ctl_err <= ctl_err + 1;
    end

    // ---------------- checking helpers ----------------
    int n_cmp = 0;
    int n_bad = 0;
    int s_we, s_re, s_pop, s_done, s_drop, s_flow, s_ctl, s_log;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic snap();
        s_we = we_tot; s_re = re_tot; s_pop = pop_tot; s_done = done_tot;
        s_drop = sel_drop; s_flow = flow_err; s_ctl = ctl_err;
        s_log = rd_log.size();
    endtask

    task automatic start_pulse(input logic w, input logic r);
        @(posedge clk); #1;
        wr_start = w; rd_start = r;
        @(posedge clk); #1;
        wr_start = 1'b0; rd_start = 1'b0;
    endtask

    // vmode: 0 valid held, 1 valid every other cycle, 2 random valid
    // rmode: 0 ready held, 1 ready low for 20 cycles mid-page, 2 random ready
    task automatic run_xfer(input bit is_wr, input int vmode, input int rmode,
                            input bit mid_rd, input int stop_at, output bit to);
        int  idx = 0;
        int  c = 0;
        bit  seen_done = 1'b0;
        bit  acc;
        logic v;
        to = 1'b0;
        while (!seen_done) begin
            if (is_wr) begin
                case (vmode)
                    0:       v = 1'b1;
                    1:       v = ~c[0];
                    default: v = 1'($urandom_range(0, 1));
                endcase
                wdata_valid = (idx < PW) ? v : 1'b0;
                wdata       = (idx < PW) ? wr_words[idx] : '0;
            end else begin
                case (rmode)
                    0:       rdata_ready = 1'b1;
                    1:       rdata_ready = !(c >= 600 && c < 620);
                    default: rdata_ready = 1'($urandom_range(0, 1));
                endcase
            end
            rd_start = (mid_rd && c == 100);
            @(negedge clk);
            acc = wdata_valid && wdata_ready;
            if (done) seen_done = 1'b1;
            @(posedge clk); #1;
            rd_start = 1'b0;
            if (acc) idx++;
            c++;
            if (stop_at > 0 && idx == stop_at) return;
            if (c > XFER_BUDGET) begin
                to = 1'b1;
                seen_done = 1'b1;
            end
        end
        wdata_valid = 1'b0;
        rdata_ready = 1'b0;
    endtask

    task automatic check_write(input string tag, input bit to);
        int bad = 0;
        for (int i = 0; i < PW; i++) if (bmem[i] !== wr_words[i]) bad++;
        chk({tag, "_timeout"},  32'(to), 0);
        chk({tag, "_we_count"}, 32'(we_tot - s_we), PW);
        chk({tag, "_mem_errs"}, 32'(bad), 0);
        chk({tag, "_first"},    32'(bmem[0]), 32'(wr_words[0]));
        chk({tag, "_last"},     32'(bmem[PW-1]), 32'(wr_words[PW-1]));
        chk({tag, "_re_count"}, 32'(re_tot - s_re), 0);
        chk({tag, "_done_cnt"}, 32'(done_tot - s_done), 1);
        chk({tag, "_sel_drop"}, 32'(sel_drop - s_drop), 0);
        chk({tag, "_ctl_err"},  32'(ctl_err - s_ctl), 0);
        @(negedge clk);
        chk({tag, "_busy_after"}, 32'(busy), 0);
        chk({tag, "_sel_after"},  32'(buf_sel), 0);
    endtask

    task automatic check_read(input string tag, input bit to, input logic exp_err);
        int bad = 0;
        for (int i = 0; i < PW; i++) begin
            if (s_log + i >= rd_log.size()) bad++;
            else if (rd_log[s_log + i] !== fill_data[i]) bad++;
        end
        chk({tag, "_timeout"},   32'(to), 0);
        chk({tag, "_pop_count"}, 32'(pop_tot - s_pop), PW);
        chk({tag, "_data_errs"}, 32'(bad), 0);
        chk({tag, "_re_count"},  32'(re_tot - s_re), PW);
        chk({tag, "_we_count"},  32'(we_tot - s_we), 0);
        chk({tag, "_flow_err"},  32'(flow_err - s_flow), 0);
        chk({tag, "_done_cnt"},  32'(done_tot - s_done), 1);
        chk({tag, "_done_lag"},  32'(done_cyc - last_pop_cyc), 1);
        chk({tag, "_sel_drop"},  32'(sel_drop - s_drop), 0);
        chk({tag, "_ctl_err"},   32'(ctl_err - s_ctl), 0);
        chk({tag, "_rd_err"},    32'(rd_err), 32'(exp_err));
        @(negedge clk);
        chk({tag, "_busy_after"}, 32'(busy), 0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        bit to;

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_buf_sel", 32'(buf_sel), 0);
        chk("rst_buf_we",  32'(buf_we), 0);
        chk("rst_buf_re",  32'(buf_re), 0);
        chk("rst_buf_in",  32'(buf_in), 0);
        chk("rst_wready",  32'(wdata_ready), 0);
        chk("rst_rvalid",  32'(rdata_valid), 0);
        chk("rst_rdata",   32'(rdata), 0);
        chk("rst_busy",    32'(busy), 0);
        chk("rst_done",    32'(done), 0);
        chk("rst_rd_err",  32'(rd_err), 0);
        @(posedge clk); #1 rst = 1'b0;

        // write 0..PW-1 with valid held high
        for (int i = 0; i < PW; i++) wr_words[i] = DW'(i);
        snap();
        start_pulse(1'b1, 1'b0);
        run_xfer(1'b1, 0, 0, 1'b0, 0, to);
        check_write("wr_seq", to);

        // write with valid toggling every other cycle
        for (int i = 0; i < PW; i++) wr_words[i] = DW'($urandom);
        snap();
        start_pulse(1'b1, 1'b0);
        run_xfer(1'b1, 1, 0, 1'b0, 0, to);
        check_write("wr_toggle", to);

        // read a page preloaded with 0xA000+i, host always ready
        for (int i = 0; i < PW; i++) fill_data[i] = DW'(16'hA000 + i);
        page_filled = 1'b1;
        @(posedge clk); #1 fill_req = 1'b1;
        @(posedge clk); #1 fill_req = 1'b0;
        snap();
        start_pulse(1'b0, 1'b1);
        run_xfer(1'b0, 0, 0, 1'b0, 0, to);
        check_read("rd_seq", to, 1'b0);
        chk("rd_seq_first", 32'(rd_log[s_log]), 32'h0000A000);
        chk("rd_seq_last",  32'(rd_log[s_log + PW - 1]), 32'h0000A7FF);

        // read with a 20-cycle host stall mid-page, random page data
        for (int i = 0; i < PW; i++) fill_data[i] = DW'($urandom);
        @(posedge clk); #1 fill_req = 1'b1;
        @(posedge clk); #1 fill_req = 1'b0;
        snap();
        start_pulse(1'b0, 1'b1);
        run_xfer(1'b0, 0, 1, 1'b0, 0, to);
        check_read("rd_stall", to, 1'b0);

        // read of a page the controller never signalled as filled
        page_filled = 1'b0;
        snap();
        start_pulse(1'b0, 1'b1);
        run_xfer(1'b0, 0, 2, 1'b0, 0, to);
        check_read("rd_nofill", to, 1'b1);
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("rd_err_sticky", 32'(rd_err), 1);

        // simultaneous starts, then rd_start during the write
        for (int i = 0; i < PW; i++) wr_words[i] = DW'($urandom);
        snap();
        start_pulse(1'b1, 1'b1);
        @(negedge clk);
        chk("rd_err_cleared", 32'(rd_err), 0);
        @(posedge clk); #1;
        run_xfer(1'b1, 2, 0, 1'b1, 0, to);
        check_write("wr_both", to);

        // reset during a write at word 1000
        for (int i = 0; i < PW; i++) wr_words[i] = DW'($urandom);
        snap();
        start_pulse(1'b1, 1'b0);
        run_xfer(1'b1, 0, 0, 1'b0, 1000, to);
        chk("abort_reached", 32'(busy), 1);
        rst = 1'b1;
        #1;
        chk("abort_buf_sel", 32'(buf_sel), 0);
        chk("abort_buf_we",  32'(buf_we), 0);
        chk("abort_buf_in",  32'(buf_in), 0);
        chk("abort_wready",  32'(wdata_ready), 0);
        chk("abort_busy",    32'(busy), 0);
        chk("abort_done",    32'(done), 0);
        wdata_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("abort_no_done", 32'(done_tot - s_done), 0);
        @(posedge clk); #1 rst = 1'b0;

        // following write lands at buffer addresses 0..PW-1
        for (int i = 0; i < PW; i++) wr_words[i] = DW'($urandom);
        snap();
        start_pulse(1'b1, 1'b0);
        run_xfer(1'b1, 2, 0, 1'b0, 0, to);
        check_write("wr_after_rst", to);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
